soc_bus_xbar: RTL and testbench
===============================

# soc_bus_xbar

Parametrised request/grant memory-bus crossbar connecting NB_MASTER initiators (core data, debug, SPI-slave DMA) to NB_SLAVE targets (instruction RAM, data RAM, APB peripheral bridge). It is the generalised successor of the fixed 3×3 SoC interconnect. Over the fixed version it adds:
- a parametric address map;
- per-slave round-robin arbitration;
- per-slave outstanding-response tracking;
- decode-error responses for unmapped addresses.

## Interface
Parameters:
- NB_MASTER, 3, number of initiator ports (≥1)
- NB_SLAVE, 3, number of target ports (≥1)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; multiple of 8
- MAX_OUTSTANDING, 2, per-slave response-tracking depth (≥1)
- START_ADDR, {32'h1A10_0000, 32'h0010_0000, 32'h0000_0000}, packed [NB_SLAVE][ADDR_WIDTH], inclusive region base, slave 0 in LSBs
- END_ADDR, {32'h1A11_FFFF, 32'h0FFF_FFFF, 32'h000F_FFFF}, inclusive region end
- ERR_DATA, 32'hBADA_CCE5, read data returned on decode error

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- m_req_i  in  [NB_MASTER]  request valid
- m_addr_i  in  [NB_MASTER][ADDR_WIDTH]  address
- m_we_i  in  [NB_MASTER]  1 = write
- m_be_i  in  [NB_MASTER][DATA_WIDTH/8]  byte enables
- m_wdata_i  in  [NB_MASTER][DATA_WIDTH]  write data
- m_gnt_o  out  [NB_MASTER]  request accepted
- m_rvalid_o  out  [NB_MASTER]  response valid, one cycle
- m_rdata_o  out  [NB_MASTER][DATA_WIDTH]  read data
- m_err_o  out  [NB_MASTER]  decode error flag, qualified by m_rvalid_o
- s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o  out  [NB_SLAVE][…]  forwarded request
- s_gnt_i  in  [NB_SLAVE]  slave accepts request
- s_rvalid_i  in  [NB_SLAVE]  slave response valid
- s_rdata_i  in  [NB_SLAVE][DATA_WIDTH]  slave read data
- resp_orphan_o  out  1  one-cycle pulse: a slave response arrived with no tracked owner

## Operation
Address decode:
- Slave s is hit when START_ADDR[s] ≤ addr ≤ END_ADDR[s].
- If regions overlap, the lowest index wins.
- No hit = decode error.

Request rules:
- Each master has at most one transaction outstanding.
- Flag busy[m] sets on the m_gnt_o handshake.
- While busy[m] is set, m_req_i is ignored and m_gnt_o[m] = 0.

Arbitration and forwarding:
- One round-robin arbiter per slave, over non-busy masters requesting that slave.
- The priority pointer moves to (granted index + 1) mod NB_MASTER only on the handshake s_req_o && s_gnt_i. An unaccepted request keeps the pointer.
- The request path is combinational: the selected master's req/addr/we/be/wdata drive s_*_o, and m_gnt_o[m] = s_gnt_i[s] for the selected master.
- Masters must hold request fields stable until granted.

Per-slave ID FIFO:
- Depth MAX_OUTSTANDING, holds the master index.
- Push on handshake; pop on s_rvalid_i.
- When the FIFO holds MAX_OUTSTANDING entries, s_req_o[s] is forced to 0 (so no grant). This holds even if a pop occurs in the same cycle.
- Simultaneous push and pop leaves the count unchanged.
- Slaves respond in order.

Response:
- On s_rvalid_i[s], the popped master index receives registered m_rvalid_o, m_rdata_o = s_rdata_i[s], m_err_o = 0.
- s_rvalid_i with an empty FIFO is dropped and pulses resp_orphan_o.

Decode error:
- m_gnt_o[m] = 1 in the same cycle as the request; no slave is touched.
- Next cycle: m_rvalid_o = 1, m_err_o = 1, m_rdata_o = ERR_DATA.

Busy clearing:
- busy[m] clears on the edge that sets m_rvalid_o[m].
- The master may therefore be granted again in the cycle its m_rvalid_o is high.

## Timing
- Reset (synchronous, rst_n = 0 at an edge) gives:
  - all busy flags 0, FIFOs empty, RR pointers 0;
  - m_rvalid_o = 0, m_err_o = 0, m_rdata_o = 0, resp_orphan_o = 0.
- Combinational outputs s_req_o and m_gnt_o are 0 while in reset.
- Request-to-grant latency: 0 cycles (combinational through the arbiter).
- Response latency: m_rvalid_o one cycle after s_rvalid_i; decode error one cycle after m_gnt_o.
- No combinational path from s_rvalid_i/s_rdata_i to master outputs.
- Two slaves can never respond to the same master in the same cycle (guaranteed by one-outstanding-per-master).
- Reset mid-transaction: in-flight transactions are abandoned. A late s_rvalid_i after reset is an orphan (pulse, dropped).

## Structure
- Package soc_bus_pkg: default address-map constants, ERR_DATA default, and decode function addr → {hit, slave index}.
- Sub-module soc_bus_rr_arb (parametric N requesters, registered pointer, advance-on-handshake input), instantiated NB_SLAVE times.
- ID FIFOs and response registers live inline in soc_bus_xbar.

## Test plan
- Master 0 reads 0x0000_0100; slave 0 grants immediately and returns rvalid 2 cycles later with 0x1234_5678 → m_rvalid_o[0] one cycle after s_rvalid_i[0], rdata 0x1234_5678, err 0.
- Masters 0, 1, 2 continuously request slave 1 → grants rotate 0, 1, 2, 0. A stalled s_gnt_i keeps the same master selected.
- Master 1 accesses 0x2000_0000 → gnt same cycle, next cycle rvalid = 1, err = 1, rdata = 0xBADA_CCE5; no s_req_o asserted.
- MAX_OUTSTANDING = 2 and slave 2 withholds rvalid; three masters target it → only two handshakes, third s_req_o held 0. After one rvalid the third is granted next cycle; responses route in grant order.
- s_rvalid_i[0] pulsed with an empty FIFO → resp_orphan_o = 1 for one cycle, no m_rvalid_o.
- rst_n low for one edge while master 0 is outstanding → all busy cleared and outputs 0. The subsequent late rvalid gives an orphan pulse, and a new request from master 0 is granted.

Source files
------------

// File: rtl/soc_bus_xbar_pkg.sv
// Shared constants and address decode for the SoC bus crossbar.
// Default map: slave 0 IRAM, slave 1 DRAM, slave 2 APB bridge.
package soc_bus_pkg;

    localparam int MAX_SLV = 8;
    localparam int MAX_AW  = 64;
    localparam int SIDX_W  = 3;

    localparam logic [2:0][31:0] START_DEF = {
        32'h1A10_0000, 32'h0010_0000, 32'h0000_0000
    };
    localparam logic [2:0][31:0] END_DEF = {
        32'h1A11_FFFF, 32'h0FFF_FFFF, 32'h000F_FFFF
    };
    localparam logic [31:0] ERR_DATA_DEF = 32'hBADA_CCE5;

    typedef logic [MAX_SLV-1:0][MAX_AW-1:0] amap_t;

    typedef struct packed {
        logic              hit;
        logic [SIDX_W-1:0] idx;
    } dec_t;

    // Walk downwards so the lowest matching region wins on overlap.
    function automatic dec_t decode(
        input logic [MAX_AW-1:0] addr,
        input amap_t             st,
        input amap_t             en,
        input int                nb
    );
        dec_t d;
        d = '0;
        for (int s = MAX_SLV - 1; s >= 0; s--) begin
            if (s < nb && addr >= st[s] && addr <= en[s]) begin
                d.hit = 1'b1;
                d.idx = SIDX_W'(s);
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/soc_bus_xbar_if.sv
// Master- and slave-side signal bundle of the SoC bus crossbar.
interface soc_bus_xbar_if #(
    parameter int NB_MASTER  = 3,
    parameter int NB_SLAVE   = 3,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [NB_MASTER-1:0]                   m_req_i;
    logic [NB_MASTER-1:0][ADDR_WIDTH-1:0]   m_addr_i;
    logic [NB_MASTER-1:0]                   m_we_i;
    logic [NB_MASTER-1:0][DATA_WIDTH/8-1:0] m_be_i;
    logic [NB_MASTER-1:0][DATA_WIDTH-1:0]   m_wdata_i;
    logic [NB_MASTER-1:0]                   m_gnt_o;
    logic [NB_MASTER-1:0]                   m_rvalid_o;
    logic [NB_MASTER-1:0][DATA_WIDTH-1:0]   m_rdata_o;
    logic [NB_MASTER-1:0]                   m_err_o;

    logic [NB_SLAVE-1:0]                    s_req_o;
    logic [NB_SLAVE-1:0][ADDR_WIDTH-1:0]    s_addr_o;
    logic [NB_SLAVE-1:0]                    s_we_o;
    logic [NB_SLAVE-1:0][DATA_WIDTH/8-1:0]  s_be_o;
    logic [NB_SLAVE-1:0][DATA_WIDTH-1:0]    s_wdata_o;
    logic [NB_SLAVE-1:0]                    s_gnt_i;
    logic [NB_SLAVE-1:0]                    s_rvalid_i;
    logic [NB_SLAVE-1:0][DATA_WIDTH-1:0]    s_rdata_i;
    logic                                   resp_orphan_o;

    modport slave (
        input  m_req_i, m_addr_i, m_we_i, m_be_i, m_wdata_i,
        input  s_gnt_i, s_rvalid_i, s_rdata_i,
        output m_gnt_o, m_rvalid_o, m_rdata_o, m_err_o,
        output s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o,
        output resp_orphan_o
    );

    modport master (
        output m_req_i, m_addr_i, m_we_i, m_be_i, m_wdata_i,
        output s_gnt_i, s_rvalid_i, s_rdata_i,
        input  m_gnt_o, m_rvalid_o, m_rdata_o, m_err_o,
        input  s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o,
        input  resp_orphan_o
    );

endinterface

// File: rtl/soc_bus_xbar_arb.sv
// Round-robin arbiter; pointer advances past the winner on handshake.
module soc_bus_rr_arb #(
    parameter  int N  = 3,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic         adv_i,
    output logic [IW-1:0] idx_o,
    output logic         vld_o
);

    logic [IW-1:0] ptr_q, ptr_d;

    // Scan from the far end so the requester closest to ptr wins.
    always_comb begin
        idx_o = '0;
        vld_o = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_q) + k) % N]) begin
                idx_o = IW'((int'(ptr_q) + k) % N);
                vld_o = 1'b1;
            end
        end
        ptr_d = ptr_q;
        if (adv_i && vld_o) begin
            ptr_d = (int'(idx_o) == N - 1) ? '0 : idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/soc_bus_xbar.sv
// Parametric request/grant crossbar: decode, per-slave RR arbitration,
// in-order response routing through per-slave ID FIFOs.
module soc_bus_xbar
    import soc_bus_pkg::*;
#(
    parameter int NB_MASTER       = 3,
    parameter int NB_SLAVE        = 3,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter logic [NB_SLAVE-1:0][ADDR_WIDTH-1:0] START_ADDR = START_DEF,
    parameter logic [NB_SLAVE-1:0][ADDR_WIDTH-1:0] END_ADDR   = END_DEF,
    parameter logic [DATA_WIDTH-1:0]               ERR_DATA   = ERR_DATA_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    soc_bus_xbar_if.slave bus
);

    localparam int MW = (NB_MASTER > 1) ? $clog2(NB_MASTER) : 1;
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    amap_t                             st_m, en_m;
    dec_t                              dec [NB_MASTER];
    logic [NB_MASTER-1:0]              avail, derr, gnt;
    logic [NB_SLAVE-1:0][NB_MASTER-1:0] sreq;
    logic [NB_SLAVE-1:0][MW-1:0]       sel;
    logic [NB_SLAVE-1:0]               sel_vld, full, s_req, hs, pop;

    logic [NB_MASTER-1:0]                 busy_q, busy_d;
    logic [NB_MASTER-1:0]                 rvalid_q, rvalid_d;
    logic [NB_MASTER-1:0]                 err_q, err_d;
    logic [NB_MASTER-1:0][DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                                 orphan_q, orphan_d;

    logic [NB_SLAVE-1:0][CW-1:0] cnt_q, cnt_d;
    logic [NB_SLAVE-1:0][PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [MW-1:0]               mem_q [NB_SLAVE][MAX_OUTSTANDING];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        st_m = '0;
        en_m = '0;
        for (int s = 0; s < NB_SLAVE; s++) begin
            st_m[s] = MAX_AW'(START_ADDR[s]);
            en_m[s] = MAX_AW'(END_ADDR[s]);
        end
    end

    // Gating with rst_n keeps every combinational request/grant low in reset.
    always_comb begin
        for (int m = 0; m < NB_MASTER; m++) begin
            dec[m]   = decode(MAX_AW'(bus.m_addr_i[m]), st_m, en_m, NB_SLAVE);
            avail[m] = rst_n && bus.m_req_i[m] && !busy_q[m];
            derr[m]  = avail[m] && !dec[m].hit;
        end
        for (int s = 0; s < NB_SLAVE; s++) begin
            for (int m = 0; m < NB_MASTER; m++) begin
                sreq[s][m] = avail[m] && dec[m].hit &&
                             (int'(dec[m].idx) == s);
            end
        end
    end

    for (genvar s = 0; s < NB_SLAVE; s++) begin : g_arb
        soc_bus_rr_arb #(.N(NB_MASTER)) u_arb (
            .clk   (clk),
            .rst_n (rst_n),
            .req_i (sreq[s]),
            .adv_i (hs[s]),
            .idx_o (sel[s]),
            .vld_o (sel_vld[s])
        );
    end

    always_comb begin
        for (int s = 0; s < NB_SLAVE; s++) begin
            full[s]  = (cnt_q[s] == CW'(MAX_OUTSTANDING));
            s_req[s] = sel_vld[s] && !full[s];
            hs[s]    = s_req[s] && bus.s_gnt_i[s];
            pop[s]   = bus.s_rvalid_i[s] && (cnt_q[s] != '0);
            bus.s_addr_o[s]  = bus.m_addr_i[sel[s]];
            bus.s_we_o[s]    = bus.m_we_i[sel[s]];
            bus.s_be_o[s]    = bus.m_be_i[sel[s]];
            bus.s_wdata_o[s] = bus.m_wdata_i[sel[s]];
        end
    end

    always_comb begin
        gnt = derr;
        for (int s = 0; s < NB_SLAVE; s++) begin
            for (int m = 0; m < NB_MASTER; m++) begin
                if (s_req[s] && int'(sel[s]) == m) begin
                    gnt[m] = gnt[m] | bus.s_gnt_i[s];
                end
            end
        end
    end

    always_comb begin
        rvalid_d = '0;
        err_d    = '0;
        rdata_d  = rdata_q;
        orphan_d = 1'b0;
        for (int s = 0; s < NB_SLAVE; s++) begin
            cnt_d[s] = cnt_q[s] + CW'(hs[s]) - CW'(pop[s]);
            wp_d[s]  = hs[s]  ? ptr_inc(wp_q[s]) : wp_q[s];
            rp_d[s]  = pop[s] ? ptr_inc(rp_q[s]) : rp_q[s];
            if (bus.s_rvalid_i[s] && !pop[s]) orphan_d = 1'b1;
            if (pop[s]) begin
                rvalid_d[mem_q[s][rp_q[s]]] = 1'b1;
                rdata_d[mem_q[s][rp_q[s]]]  = bus.s_rdata_i[s];
            end
        end
        for (int m = 0; m < NB_MASTER; m++) begin
            if (derr[m]) begin
                rvalid_d[m] = 1'b1;
                err_d[m]    = 1'b1;
                rdata_d[m]  = ERR_DATA;
            end
        end
        // A decode error sets and clears busy on the same edge.
        busy_d = (busy_q | gnt) & ~rvalid_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q   <= '0;
            rvalid_q <= '0;
            err_q    <= '0;
            rdata_q  <= '0;
            orphan_q <= 1'b0;
            cnt_q    <= '0;
            wp_q     <= '0;
            rp_q     <= '0;
        end else begin
            busy_q   <= busy_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            orphan_q <= orphan_d;
            cnt_q    <= cnt_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < NB_SLAVE; s++) begin
            if (hs[s]) mem_q[s][wp_q[s]] <= sel[s];
        end
    end

    assign bus.s_req_o       = s_req;
    assign bus.m_gnt_o       = gnt;
    assign bus.m_rvalid_o    = rvalid_q;
    assign bus.m_rdata_o     = rdata_q;
    assign bus.m_err_o       = err_q;
    assign bus.resp_orphan_o = orphan_q;

endmodule

// File: tb/tb_soc_bus_xbar.sv
// Directed bench for soc_bus_xbar with the default 3x3 address map.
module tb_soc_bus_xbar;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    soc_bus_xbar_if #(
        .NB_MASTER(3), .NB_SLAVE(3),
        .ADDR_WIDTH(32), .DATA_WIDTH(32)
    ) bus ();

    soc_bus_xbar dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.m_req_i    = '0;
        bus.m_addr_i   = '0;
        bus.m_we_i     = '0;
        bus.m_be_i     = '1;
        bus.m_wdata_i  = '0;
        bus.s_gnt_i    = '0;
        bus.s_rvalid_i = '0;
        bus.s_rdata_i  = '0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        bus.m_req_i[0]  = 1'b1;
        bus.m_addr_i[0] = 32'h0000_0100;
        bus.s_gnt_i[0]  = 1'b1;
        step();
        step();
        n_cmp++; if (bus.m_rvalid_o !== 3'b000) begin n_err++;
            $display("FAIL rst_rvalid got=%b exp=000", bus.m_rvalid_o); end
        n_cmp++; if (bus.m_err_o !== 3'b000) begin n_err++;
            $display("FAIL rst_err got=%b exp=000", bus.m_err_o); end
        n_cmp++; if (bus.m_rdata_o !== 96'h0) begin n_err++;
            $display("FAIL rst_rdata got=%h exp=0", bus.m_rdata_o); end
        n_cmp++; if (bus.resp_orphan_o !== 1'b0) begin n_err++;
            $display("FAIL rst_orphan got=%b exp=0", bus.resp_orphan_o); end
        n_cmp++; if (bus.s_req_o !== 3'b000) begin n_err++;
            $display("FAIL rst_sreq got=%b exp=000", bus.s_req_o); end
        n_cmp++; if (bus.m_gnt_o !== 3'b000) begin n_err++;
            $display("FAIL rst_gnt got=%b exp=000", bus.m_gnt_o); end
        idle();
        rst_n = 1'b1;
    endtask

    task automatic test_read();
        bus.m_req_i[0]  = 1'b1;
        bus.m_addr_i[0] = 32'h0000_0100;
        bus.s_gnt_i[0]  = 1'b1;
        #1;
        n_cmp++; if (bus.s_req_o !== 3'b001) begin n_err++;
            $display("FAIL rd_sreq got=%b exp=001", bus.s_req_o); end
        n_cmp++; if (bus.m_gnt_o !== 3'b001) begin n_err++;
            $display("FAIL rd_gnt got=%b exp=001", bus.m_gnt_o); end
        n_cmp++; if (bus.s_addr_o[0] !== 32'h0000_0100) begin n_err++;
            $display("FAIL rd_saddr got=%h exp=00000100", bus.s_addr_o[0]); end
        step();
        #1;
        n_cmp++; if (bus.m_gnt_o !== 3'b000) begin n_err++;
            $display("FAIL rd_busy_gnt got=%b exp=000", bus.m_gnt_o); end
        n_cmp++; if (bus.s_req_o !== 3'b000) begin n_err++;
            $display("FAIL rd_busy_sreq got=%b exp=000", bus.s_req_o); end
        idle();
        step();
        bus.s_rvalid_i[0] = 1'b1;
        bus.s_rdata_i[0]  = 32'h1234_5678;
        #1;
        n_cmp++; if (bus.m_rvalid_o !== 3'b000) begin n_err++;
            $display("FAIL rd_comb_rv got=%b exp=000", bus.m_rvalid_o); end
        step();
        idle();
        n_cmp++; if (bus.m_rvalid_o !== 3'b001) begin n_err++;
            $display("FAIL rd_rvalid got=%b exp=001", bus.m_rvalid_o); end
        n_cmp++; if (bus.m_rdata_o[0] !== 32'h1234_5678) begin n_err++;
            $display("FAIL rd_rdata got=%h exp=12345678", bus.m_rdata_o[0]); end
        n_cmp++; if (bus.m_err_o !== 3'b000) begin n_err++;
            $display("FAIL rd_err got=%b exp=000", bus.m_err_o); end
        step();
        n_cmp++; if (bus.m_rvalid_o !== 3'b000) begin n_err++;
            $display("FAIL rd_rv_pulse got=%b exp=000", bus.m_rvalid_o); end
    endtask

    task automatic test_rr();
        bus.m_req_i     = 3'b111;
        bus.m_addr_i[0] = 32'h0010_0000;
        bus.m_addr_i[1] = 32'h0010_0004;
        bus.m_addr_i[2] = 32'h0010_0008;
        #1;
        n_cmp++; if (bus.s_req_o !== 3'b010) begin n_err++;
            $display("FAIL rr_sreq got=%b exp=010", bus.s_req_o); end
        n_cmp++; if (bus.m_gnt_o !== 3'b000) begin n_err++;
            $display("FAIL rr_stall_gnt got=%b exp=000", bus.m_gnt_o); end
        step();
        n_cmp++; if (bus.s_addr_o[1] !== 32'h0010_0000) begin n_err++;
            $display("FAIL rr_stall_sel got=%h exp=00100000", bus.s_addr_o[1]); end
        bus.s_gnt_i[1] = 1'b1;
        #1;
        n_cmp++; if (bus.m_gnt_o !== 3'b001) begin n_err++;
            $display("FAIL rr_g0 got=%b exp=001", bus.m_gnt_o); end
        step();
        bus.s_rvalid_i[1] = 1'b1;
        bus.s_rdata_i[1]  = 32'hA1A1_0001;
        #1;
        n_cmp++; if (bus.m_gnt_o !== 3'b010) begin n_err++;
            $display("FAIL rr_g1 got=%b exp=010", bus.m_gnt_o); end
        n_cmp++; if (bus.s_addr_o[1] !== 32'h0010_0004) begin n_err++;
            $display("FAIL rr_a1 got=%h exp=00100004", bus.s_addr_o[1]); end
        step();
        bus.s_rdata_i[1] = 32'hA1A1_0002;
        #1;
        n_cmp++; if (bus.m_gnt_o !== 3'b100) begin n_err++;
            $display("FAIL rr_g2 got=%b exp=100", bus.m_gnt_o); end
        n_cmp++; if (bus.m_rvalid_o !== 3'b001) begin n_err++;
            $display("FAIL rr_rv0 got=%b exp=001", bus.m_rvalid_o); end
        n_cmp++; if (bus.m_rdata_o[0] !== 32'hA1A1_0001) begin n_err++;
            $display("FAIL rr_d0 got=%h exp=a1a10001", bus.m_rdata_o[0]); end
        step();
        bus.s_rdata_i[1] = 32'hA1A1_0003;
        #1;
        n_cmp++; if (bus.m_gnt_o !== 3'b001) begin n_err++;
            $display("FAIL rr_g0b got=%b exp=001", bus.m_gnt_o); end
        n_cmp++; if (bus.m_rdata_o[1] !== 32'hA1A1_0002) begin n_err++;
            $display("FAIL rr_d1 got=%h exp=a1a10002", bus.m_rdata_o[1]); end
        step();
        bus.m_req_i      = '0;
        bus.s_gnt_i      = '0;
        bus.s_rdata_i[1] = 32'hA1A1_0004;
        #1;
        n_cmp++; if (bus.m_rvalid_o !== 3'b100) begin n_err++;
            $display("FAIL rr_rv2 got=%b exp=100", bus.m_rvalid_o); end
        n_cmp++; if (bus.m_rdata_o[2] !== 32'hA1A1_0003) begin n_err++;
            $display("FAIL rr_d2 got=%h exp=a1a10003", bus.m_rdata_o[2]); end
        step();
        idle();
        n_cmp++; if (bus.m_rdata_o[0] !== 32'hA1A1_0004) begin n_err++;
            $display("FAIL rr_d0b got=%h exp=a1a10004", bus.m_rdata_o[0]); end
        step();
    endtask

    task automatic test_decode_err();
        bus.m_req_i[1]  = 1'b1;
        bus.m_addr_i[1] = 32'h2000_0000;
        bus.s_gnt_i     = 3'b111;
        #1;
        n_cmp++; if (bus.m_gnt_o !== 3'b010) begin n_err++;
            $display("FAIL de_gnt got=%b exp=010", bus.m_gnt_o); end
        n_cmp++; if (bus.s_req_o !== 3'b000) begin n_err++;
            $display("FAIL de_sreq got=%b exp=000", bus.s_req_o); end
        step();
        idle();
        #1;
        n_cmp++; if (bus.m_rvalid_o !== 3'b010) begin n_err++;
            $display("FAIL de_rvalid got=%b exp=010", bus.m_rvalid_o); end
        n_cmp++; if (bus.m_err_o !== 3'b010) begin n_err++;
            $display("FAIL de_err got=%b exp=010", bus.m_err_o); end
        n_cmp++; if (bus.m_rdata_o[1] !== 32'hBADA_CCE5) begin n_err++;
            $display("FAIL de_rdata got=%h exp=badacce5", bus.m_rdata_o[1]); end
        step();
        n_cmp++; if (bus.m_err_o !== 3'b000) begin n_err++;
            $display("FAIL de_err_pulse got=%b exp=000", bus.m_err_o); end
    endtask

    task automatic test_outstanding();
        bus.m_req_i     = 3'b111;
        bus.m_addr_i[0] = 32'h1A10_0000;
        bus.m_addr_i[1] = 32'h1A10_0004;
        bus.m_addr_i[2] = 32'h1A10_0008;
        bus.s_gnt_i[2]  = 1'b1;
        #1;
        n_cmp++; if (bus.m_gnt_o !== 3'b001) begin n_err++;
            $display("FAIL os_g0 got=%b exp=001", bus.m_gnt_o); end
        step();
        n_cmp++; if (bus.m_gnt_o !== 3'b010) begin n_err++;
            $display("FAIL os_g1 got=%b exp=010", bus.m_gnt_o); end
        step();
        n_cmp++; if (bus.s_req_o !== 3'b000) begin n_err++;
            $display("FAIL os_full got=%b exp=000", bus.s_req_o); end
        step();
        bus.s_rvalid_i[2] = 1'b1;
        bus.s_rdata_i[2]  = 32'hB0B0_0000;
        #1;
        n_cmp++; if (bus.s_req_o !== 3'b000) begin n_err++;
            $display("FAIL os_full_pop got=%b exp=000", bus.s_req_o); end
        step();
        bus.s_rvalid_i[2] = 1'b0;
        bus.m_req_i[0]    = 1'b0;
        #1;
        n_cmp++; if (bus.m_gnt_o !== 3'b100) begin n_err++;
            $display("FAIL os_g2 got=%b exp=100", bus.m_gnt_o); end
        n_cmp++; if (bus.s_addr_o[2] !== 32'h1A10_0008) begin n_err++;
            $display("FAIL os_a2 got=%h exp=1a100008", bus.s_addr_o[2]); end
        n_cmp++; if (bus.m_rvalid_o !== 3'b001) begin n_err++;
            $display("FAIL os_rv0 got=%b exp=001", bus.m_rvalid_o); end
        n_cmp++; if (bus.m_rdata_o[0] !== 32'hB0B0_0000) begin n_err++;
            $display("FAIL os_d0 got=%h exp=b0b00000", bus.m_rdata_o[0]); end
        step();
        bus.m_req_i       = '0;
        bus.s_gnt_i       = '0;
        bus.s_rvalid_i[2] = 1'b1;
        bus.s_rdata_i[2]  = 32'hB0B0_0001;
        step();
        bus.s_rdata_i[2] = 32'hB0B0_0002;
        #1;
        n_cmp++; if (bus.m_rvalid_o !== 3'b010) begin n_err++;
            $display("FAIL os_rv1 got=%b exp=010", bus.m_rvalid_o); end
        n_cmp++; if (bus.m_rdata_o[1] !== 32'hB0B0_0001) begin n_err++;
            $display("FAIL os_d1 got=%h exp=b0b00001", bus.m_rdata_o[1]); end
        step();
        idle();
        n_cmp++; if (bus.m_rvalid_o !== 3'b100) begin n_err++;
            $display("FAIL os_rv2 got=%b exp=100", bus.m_rvalid_o); end
        n_cmp++; if (bus.m_rdata_o[2] !== 32'hB0B0_0002) begin n_err++;
            $display("FAIL os_d2 got=%h exp=b0b00002", bus.m_rdata_o[2]); end
        step();
    endtask

    task automatic test_orphan();
        bus.s_rvalid_i[0] = 1'b1;
        bus.s_rdata_i[0]  = 32'hDEAD_0000;
        step();
        idle();
        n_cmp++; if (bus.resp_orphan_o !== 1'b1) begin n_err++;
            $display("FAIL orph_pulse got=%b exp=1", bus.resp_orphan_o); end
        n_cmp++; if (bus.m_rvalid_o !== 3'b000) begin n_err++;
            $display("FAIL orph_rv got=%b exp=000", bus.m_rvalid_o); end
        step();
        n_cmp++; if (bus.resp_orphan_o !== 1'b0) begin n_err++;
            $display("FAIL orph_clr got=%b exp=0", bus.resp_orphan_o); end
    endtask

    task automatic test_reset_mid();
        bus.m_req_i[0]  = 1'b1;
        bus.m_addr_i[0] = 32'h0000_0200;
        bus.s_gnt_i[0]  = 1'b1;
        #1;
        n_cmp++; if (bus.m_gnt_o !== 3'b001) begin n_err++;
            $display("FAIL rm_g0 got=%b exp=001", bus.m_gnt_o); end
        step();
        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_cmp++; if (bus.m_rvalid_o !== 3'b000) begin n_err++;
            $display("FAIL rm_rv got=%b exp=000", bus.m_rvalid_o); end
        bus.s_rvalid_i[0] = 1'b1;
        step();
        idle();
        bus.m_req_i[0]  = 1'b1;
        bus.m_addr_i[0] = 32'h0000_0300;
        bus.s_gnt_i[0]  = 1'b1;
        #1;
        n_cmp++; if (bus.resp_orphan_o !== 1'b1) begin n_err++;
            $display("FAIL rm_orph got=%b exp=1", bus.resp_orphan_o); end
        n_cmp++; if (bus.m_rvalid_o !== 3'b000) begin n_err++;
            $display("FAIL rm_rv2 got=%b exp=000", bus.m_rvalid_o); end
        n_cmp++; if (bus.m_gnt_o !== 3'b001) begin n_err++;
            $display("FAIL rm_regnt got=%b exp=001", bus.m_gnt_o); end
        step();
        idle();
        bus.s_rvalid_i[0] = 1'b1;
        bus.s_rdata_i[0]  = 32'h0C0F_FEE0;
        step();
        idle();
        n_cmp++; if (bus.m_rdata_o[0] !== 32'h0C0F_FEE0) begin n_err++;
            $display("FAIL rm_d0 got=%h exp=0c0ffee0", bus.m_rdata_o[0]); end
        step();
    endtask

    initial begin
        test_reset();
        step();
        test_read();
        test_rr();
        test_decode_err();
        test_outstanding();
        test_orphan();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
